// File: rtl/master_updateable_megarom_pkg.sv
// master_updateable_megarom_pkg: frame geometry and bit-position constants for the MegaROM SPI programmer
package master_updateable_megarom_pkg;
   localparam int FRAME_BITS    = 32;
   localparam int ADDR_BITS     = 19;
   localparam int BBC_ADDR_BITS = 17;
   typedef logic [5:0] cnt_t;
   localparam cnt_t ADDR_END       = 6'd19;
   localparam cnt_t RNW_BIT        = 6'd20;
   localparam cnt_t READ_LATCH_BIT = 6'd24;
   localparam cnt_t DATA_END       = 6'd28;
   localparam cnt_t WE_START       = 6'd29;
   localparam cnt_t WE_END         = 6'd31;
   localparam cnt_t FRAME_END      = 6'd32;
   localparam logic [FRAME_BITS-1:0] UNLOCK_WORD = 32'hFFFFFFFF;
endpackage

// File: rtl/master_updateable_megarom_if.sv
// master_updateable_megarom_if: programming-header SPI link
interface master_updateable_megarom_if;
   logic cpld_SCK_in;
   logic cpld_MOSI;
   logic cpld_SS;
   logic cpld_MISO;
   modport master(output cpld_SCK_in, cpld_MOSI, cpld_SS, input cpld_MISO);
   modport slave(input cpld_SCK_in, cpld_MOSI, cpld_SS, output cpld_MISO);
endinterface

// File: rtl/master_updateable_megarom_spi_edge_sync.sv
// spi_edge_sync: synchronises SPI inputs into clk and flags SCK/SS edges
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sck,
   input  logic ss,
   input  logic mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic ss_rise,
   output logic ss_fall,
   output logic ss_s,
   output logic mosi_s
);
   logic [SYNC_STAGES-1:0] sck_sr, ss_sr, mosi_sr;
   logic sck_d, ss_d;
   // synchroniser chains plus one delayed copy of SCK/SS for edge detection; SS idles high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sr  <= '0;
         ss_sr   <= '1;
         mosi_sr <= '0;
         sck_d   <= 1'b0;
         ss_d    <= 1'b1;
      end else begin
         sck_sr  <= (sck_sr << 1) | SYNC_STAGES'(sck);
         ss_sr   <= (ss_sr << 1) | SYNC_STAGES'(ss);
         mosi_sr <= (mosi_sr << 1) | SYNC_STAGES'(mosi);
         sck_d   <= sck_sr[SYNC_STAGES-1];
         ss_d    <= ss_sr[SYNC_STAGES-1];
      end
   end
   assign sck_rise = sck_sr[SYNC_STAGES-1] & ~sck_d;
   assign sck_fall = ~sck_sr[SYNC_STAGES-1] & sck_d;
   assign ss_rise  = ss_sr[SYNC_STAGES-1] & ~ss_d;
   assign ss_fall  = ~ss_sr[SYNC_STAGES-1] & ss_d;
   assign ss_s     = ss_sr[SYNC_STAGES-1];
   assign mosi_s   = mosi_sr[SYNC_STAGES-1];
endmodule

// File: rtl/master_updateable_megarom.sv
// master_updateable_megarom: BBC ROM-to-flash passthrough with SPI takeover for byte read/write
module master_updateable_megarom
   import master_updateable_megarom_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   inout  wire  [7:0]               D,
   input  logic [BBC_ADDR_BITS-1:0] bbc_A,
   input  logic [1:0]               cpld_JP,
   output logic [ADDR_BITS-1:0]     flash_A,
   output logic                     flash_nOE,
   output logic                     flash_nWE,
   master_updateable_megarom_if.slave spi
);
   logic sck_rise, sck_fall, ss_rise, ss_fall, ss_s, mosi_s;
   logic allowing_bbc_access, rnw, noe, nwe, d_oe, miso;
   cnt_t bit_cnt;
   logic [FRAME_BITS-2:0] shreg;
   logic [ADDR_BITS-1:0] addr;
   logic [7:0] rdata, wdata;
   logic [FRAME_BITS-1:0] frame;
   cnt_t nxt;
   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst_n(rst_n),
      .sck(spi.cpld_SCK_in), .ss(spi.cpld_SS), .mosi(spi.cpld_MOSI),
      .sck_rise(sck_rise), .sck_fall(sck_fall),
      .ss_rise(ss_rise), .ss_fall(ss_fall),
      .ss_s(ss_s), .mosi_s(mosi_s)
   );
   assign frame = {shreg, mosi_s};
   assign nxt   = bit_cnt + 6'd1;
   assign flash_A       = allowing_bbc_access ? {cpld_JP, bbc_A} : addr;
   assign flash_nOE     = allowing_bbc_access ? 1'b0 : noe;
   assign flash_nWE     = allowing_bbc_access ? 1'b1 : nwe;
   assign D             = (!allowing_bbc_access && d_oe) ? wdata : 8'bz;
   assign spi.cpld_MISO = miso;
   // frame sequencer: bit count selects address latch, read window, write strobe and unlock decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         allowing_bbc_access <= 1'b1;
         bit_cnt <= '0;
         shreg   <= '0;
         miso    <= 1'b0;
         noe     <= 1'b1;
         nwe     <= 1'b1;
         d_oe    <= 1'b0;
         addr    <= '0;
         rnw     <= 1'b0;
         rdata   <= '0;
         wdata   <= '0;
      end else if (ss_fall) begin
         allowing_bbc_access <= 1'b0;
         bit_cnt <= '0;
      end else if (ss_rise) begin
         bit_cnt <= '0;
         noe     <= 1'b1;
         nwe     <= 1'b1;
         d_oe    <= 1'b0;
         miso    <= 1'b0;
      end else if (sck_rise && !ss_s && bit_cnt != FRAME_END) begin
         shreg   <= frame[FRAME_BITS-2:0];
         bit_cnt <= nxt;
         if (nxt == ADDR_END) addr <= frame[ADDR_BITS-1:0];
         if (nxt == RNW_BIT) begin
            rnw <= mosi_s;
            noe <= !mosi_s;
         end
         if (nxt == READ_LATCH_BIT && rnw) begin
            rdata <= D;
            noe   <= 1'b1;
         end
         if (nxt == DATA_END && !rnw) begin
            wdata <= frame[7:0];
            d_oe  <= 1'b1;
         end
         if (nxt == WE_START && !rnw) nwe <= 1'b0;
         if (nxt == WE_END) nwe <= 1'b1;
         if (nxt == FRAME_END && frame == UNLOCK_WORD) allowing_bbc_access <= 1'b1;
      end else if (sck_fall && !ss_s) begin
         miso  <= (rnw && bit_cnt >= READ_LATCH_BIT && bit_cnt < FRAME_END) ? rdata[7] : 1'b0;
         rdata <= {rdata[6:0], 1'b0};
      end
   end
endmodule

// File: tb/tb_master_updateable_megarom.sv
// tb_master_updateable_megarom: directed checks of BBC passthrough and SPI read/write/unlock frames
module tb_master_updateable_megarom;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   wire  [7:0] D;
   logic [16:0] bbc_A = 17'h0;
   logic [1:0] cpld_JP = 2'b0;
   logic [18:0] flash_A;
   logic flash_nOE, flash_nWE;
   logic [7:0] flash_val = 8'h42;
   logic [7:0] probe = 8'h00;
   logic probe_en = 1'b0;
   int passed = 0;
   int total = 0;
   logic ev_w [64];
   logic [18:0] ev_a [64];
   logic [7:0] ev_d [64];
   int ev_n = 0;
   int stab_err = 0;
   logic prev_nwe = 1'b1;
   logic prev_noe = 1'b0;
   logic [18:0] we_a;
   logic [7:0] we_d;

   always #5 clk = ~clk;

   assign D = probe_en ? probe : (!flash_nOE && flash_nWE) ? flash_val : 8'hzz;

   master_updateable_megarom_if spi();

   master_updateable_megarom #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .D(D), .bbc_A(bbc_A), .cpld_JP(cpld_JP),
      .flash_A(flash_A), .flash_nOE(flash_nOE), .flash_nWE(flash_nWE), .spi(spi)
   );

   // strobe logger: records each nWE fall and each SPI-mode nOE fall with address and bus data
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_nwe && !flash_nWE && ev_n < 64) begin
            ev_w[ev_n] = 1'b1; ev_a[ev_n] = flash_A; ev_d[ev_n] = D; ev_n++;
            we_a = flash_A; we_d = D;
         end else if (!flash_nWE && (flash_A !== we_a || D !== we_d)) stab_err++;
         if (prev_noe && !flash_nOE && !spi.cpld_SS && ev_n < 64) begin
            ev_w[ev_n] = 1'b0; ev_a[ev_n] = flash_A; ev_d[ev_n] = D; ev_n++;
         end
         prev_nwe = flash_nWE;
         prev_noe = flash_nOE;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_xfer(input logic [31:0] w, input int nbits, input bit end_ss, output logic [31:0] rx);
      rx = '0;
      spi.cpld_SS = 1'b0;
      wait_clk(4);
      for (int i = 0; i < nbits; i++) begin
         spi.cpld_MOSI = w[31-i];
         wait_clk(4);
         rx = {rx[30:0], spi.cpld_MISO};
         spi.cpld_SCK_in = 1'b1;
         wait_clk(4);
         spi.cpld_SCK_in = 1'b0;
      end
      wait_clk(4);
      if (end_ss) begin
         spi.cpld_SS = 1'b1;
         wait_clk(6);
      end
   endtask

   task automatic test_reset();
      spi.cpld_SS = 1'b1; spi.cpld_SCK_in = 1'b0; spi.cpld_MOSI = 1'b0;
      bbc_A = 17'h12345; cpld_JP = 2'b00; rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(10);
      total++; if (flash_A !== 19'h12345) $display("FAIL reset_flash_A: got %h expected %h", flash_A, 19'h12345); else passed++;
      total++; if (flash_nOE !== 1'b0) $display("FAIL reset_nOE: got %b expected 0", flash_nOE); else passed++;
      total++; if (flash_nWE !== 1'b1) $display("FAIL reset_nWE: got %b expected 1", flash_nWE); else passed++;
      total++; if (spi.cpld_MISO !== 1'b0) $display("FAIL reset_MISO: got %b expected 0", spi.cpld_MISO); else passed++;
      total++; if (D !== 8'h42) $display("FAIL reset_D_released: got %h expected %h", D, 8'h42); else passed++;
   endtask

   task automatic test_unlock();
      logic [31:0] rx;
      spi_xfer(32'hFFFFFF00, 32, 1'b1, rx);
      bbc_A = 17'h00ABC; cpld_JP = 2'b10;
      wait_clk(2);
      total++; if (flash_A !== 19'h7FFFF) $display("FAIL locked_flash_A: got %h expected %h", flash_A, 19'h7FFFF); else passed++;
      total++; if (flash_nOE !== 1'b1) $display("FAIL locked_nOE: got %b expected 1", flash_nOE); else passed++;
      total++; if (rx[7:0] !== 8'h42) $display("FAIL locked_read_data: got %h expected %h", rx[7:0], 8'h42); else passed++;
      spi_xfer(32'hFFFFFFFF, 32, 1'b1, rx);
      wait_clk(2);
      total++; if (flash_A !== 19'h40ABC) $display("FAIL unlock_flash_A: got %h expected %h", flash_A, 19'h40ABC); else passed++;
      total++; if (flash_nOE !== 1'b0) $display("FAIL unlock_nOE: got %b expected 0", flash_nOE); else passed++;
      bbc_A = 17'h1F00F;
      wait_clk(1);
      total++; if (flash_A !== 19'h5F00F) $display("FAIL unlock_tracks_bbc: got %h expected %h", flash_A, 19'h5F00F); else passed++;
   endtask

   task automatic test_write();
      logic [31:0] rx;
      int base = ev_n;
      int st = stab_err;
      spi_xfer({19'h51234, 1'b0, 8'h89, 4'b0}, 32, 1'b0, rx);
      total++; if (D !== 8'h89) $display("FAIL write_D_driven: got %h expected %h", D, 8'h89); else passed++;
      spi.cpld_SS = 1'b1;
      wait_clk(6);
      total++; if (ev_n - base !== 1) $display("FAIL write_strobe_count: got %0d expected 1", ev_n - base); else passed++;
      total++; if (ev_w[base] !== 1'b1) $display("FAIL write_strobe_kind: got %b expected 1", ev_w[base]); else passed++;
      total++; if (ev_a[base] !== 19'h51234) $display("FAIL write_addr: got %h expected %h", ev_a[base], 19'h51234); else passed++;
      total++; if (ev_d[base] !== 8'h89) $display("FAIL write_data: got %h expected %h", ev_d[base], 8'h89); else passed++;
      total++; if (stab_err !== st) $display("FAIL write_stable: got %0d changes expected 0", stab_err - st); else passed++;
      total++; if (flash_A !== 19'h51234) $display("FAIL write_locked_A: got %h expected %h", flash_A, 19'h51234); else passed++;
      total++; if (flash_nOE !== 1'b1) $display("FAIL write_nOE: got %b expected 1", flash_nOE); else passed++;
      probe_en = 1'b1; probe = 8'h00; #1;
      total++; if (D !== 8'h00) $display("FAIL write_D_released: got %h expected %h", D, 8'h00); else passed++;
      probe_en = 1'b0;
   endtask

   task automatic test_read();
      logic [31:0] rx;
      int base = ev_n;
      flash_val = 8'h42;
      spi_xfer({19'h70F0F, 1'b1, 12'b0}, 32, 1'b1, rx);
      total++; if (ev_n - base !== 1) $display("FAIL read_strobe_count: got %0d expected 1", ev_n - base); else passed++;
      total++; if (ev_w[base] !== 1'b0) $display("FAIL read_strobe_kind: got %b expected 0", ev_w[base]); else passed++;
      total++; if (ev_a[base] !== 19'h70F0F) $display("FAIL read_addr: got %h expected %h", ev_a[base], 19'h70F0F); else passed++;
      total++; if (rx[7:0] !== 8'h42) $display("FAIL read_miso_data: got %h expected %h", rx[7:0], 8'h42); else passed++;
      total++; if (rx[31:8] !== 24'h0) $display("FAIL read_miso_idle: got %h expected %h", rx[31:8], 24'h0); else passed++;
      total++; if (flash_nOE !== 1'b1) $display("FAIL read_nOE_after: got %b expected 1", flash_nOE); else passed++;
   endtask

   task automatic test_jedec();
      logic [31:0] rx;
      logic jw [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [18:0] ja [6] = '{19'h05555, 19'h02AAA, 19'h05555, 19'h00000, 19'h00001, 19'h05555};
      logic [7:0] jd [6] = '{8'hAA, 8'h55, 8'h90, 8'hBF, 8'h07, 8'hF0};
      int base = ev_n;
      for (int i = 0; i < 6; i++) begin
         flash_val = jd[i];
         spi_xfer({ja[i], !jw[i], jw[i] ? jd[i] : 8'h00, 4'b0}, 32, 1'b1, rx);
         if (!jw[i]) begin
            total++; if (rx[7:0] !== jd[i]) $display("FAIL jedec_miso_%0d: got %h expected %h", i, rx[7:0], jd[i]); else passed++;
         end
      end
      total++; if (ev_n - base !== 6) $display("FAIL jedec_strobe_count: got %0d expected 6", ev_n - base); else passed++;
      for (int i = 0; i < 6; i++) begin
         total++; if (ev_w[base+i] !== jw[i]) $display("FAIL jedec_kind_%0d: got %b expected %b", i, ev_w[base+i], jw[i]); else passed++;
         total++; if (ev_a[base+i] !== ja[i]) $display("FAIL jedec_addr_%0d: got %h expected %h", i, ev_a[base+i], ja[i]); else passed++;
         total++; if (ev_d[base+i] !== jd[i]) $display("FAIL jedec_data_%0d: got %h expected %h", i, ev_d[base+i], jd[i]); else passed++;
      end
      flash_val = 8'h42;
   endtask

   task automatic test_partial();
      logic [31:0] rx;
      int base = ev_n;
      spi_xfer({19'h12121, 1'b0, 8'hFF, 4'b0}, 22, 1'b1, rx);
      total++; if (ev_n - base !== 0) $display("FAIL partial_strobes: got %0d expected 0", ev_n - base); else passed++;
      total++; if (flash_A !== 19'h12121) $display("FAIL partial_locked_A: got %h expected %h", flash_A, 19'h12121); else passed++;
      total++; if (flash_nOE !== 1'b1) $display("FAIL partial_nOE: got %b expected 1", flash_nOE); else passed++;
      total++; if (flash_nWE !== 1'b1) $display("FAIL partial_nWE: got %b expected 1", flash_nWE); else passed++;
      probe_en = 1'b1; probe = 8'h00; #1;
      total++; if (D !== 8'h00) $display("FAIL partial_D_released: got %h expected %h", D, 8'h00); else passed++;
      probe_en = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] rx;
      flash_val = 8'hFF;
      spi_xfer({19'h00333, 1'b1, 12'b0}, 26, 1'b0, rx);
      total++; if (spi.cpld_MISO !== 1'b1) $display("FAIL midread_MISO: got %b expected 1", spi.cpld_MISO); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (spi.cpld_MISO !== 1'b0) $display("FAIL rst_MISO: got %b expected 0", spi.cpld_MISO); else passed++;
      total++; if (flash_nOE !== 1'b0) $display("FAIL rst_nOE: got %b expected 0", flash_nOE); else passed++;
      total++; if (flash_A !== 19'h5F00F) $display("FAIL rst_flash_A: got %h expected %h", flash_A, 19'h5F00F); else passed++;
      spi.cpld_SS = 1'b1;
      wait_clk(6);
      rst_n = 1'b1;
      flash_val = 8'h42;
      wait_clk(6);
      total++; if (flash_A !== 19'h5F00F) $display("FAIL rst_bbc_A: got %h expected %h", flash_A, 19'h5F00F); else passed++;
      total++; if (flash_nOE !== 1'b0) $display("FAIL rst_bbc_nOE: got %b expected 0", flash_nOE); else passed++;
      total++; if (flash_nWE !== 1'b1) $display("FAIL rst_bbc_nWE: got %b expected 1", flash_nWE); else passed++;
      total++; if (D !== 8'h42) $display("FAIL rst_bbc_D: got %h expected %h", D, 8'h42); else passed++;
   endtask

   initial begin
      test_reset();
      test_unlock();
      test_write();
      test_read();
      test_jedec();
      test_partial();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/master_updateable_megarom.md
Name: master_updateable_megarom

Overview:
- Flash-backed MegaROM replacement for a BBC Master. Normally passes BBC ROM addresses straight through to a 512 KiB parallel flash.
- An external programmer on a 32-bit SPI slave link can take the flash over, read or write single bytes, and hand the flash back to the BBC.
- Sits between the BBC ROM socket, the flash chip and the programming header.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for cpld_SCK_in, cpld_SS and cpld_MOSI into the clk domain.

Ports:
- clk  in  1  system clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- D  inout  8  flash/BBC data bus. Driven only during SPI writes, otherwise high-Z.
- bbc_A  in  17  BBC ROM address.
- cpld_JP  in  2  jumper bank select; forms flash_A[18:17] in BBC mode.
- flash_A  out  19  flash address.
- flash_nOE  out  1  flash output enable, active low.
- flash_nWE  out  1  flash write enable, active low.
- cpld_SCK_in  in  1  SPI clock, mode 0.
- cpld_MOSI  in  1  SPI data in, MSB first.
- cpld_SS  in  1  SPI select, active low.
- cpld_MISO  out  1  SPI data out.

Behaviour:
- All SPI inputs pass through SYNC_STAGES flip-flops; SCK rise/fall are detected in clk. Each SCK phase must last at least 1 clk.
- Reset values: allowing_bbc_access=1, bit counter=0, shift register=0, cpld_MISO=0, flash_nWE=1, D high-Z.
- allowing_bbc_access=1 (BBC mode):
  - flash_A={cpld_JP,bbc_A}.
  - flash_nOE=0, flash_nWE=1, D high-Z. The flash drives the BBC bus directly.
- Frame format: 32 bits, sampled on SCK rise. Bits numbered 1..32 in arrival order.
  - Bits 1-19: A[18:0].
  - Bit 20: rnw.
  - Bits 21-28: write data (MSB first); don't-care for reads.
  - Bits 29-32: zero.
- Select edges:
  - SS falling: bit counter=0, allowing_bbc_access=0.
  - SS rising: counter cleared; nOE=1, nWE=1, D released at the next clk.
  - A partial frame performs no further action. Access remains disabled.
- In SPI mode, flash_A holds the last latched address. It is latched at bit 19 and held after the frame.
- flash_nOE=1 except during a read window.
- Read (rnw=1):
  - From the clk after bit 20, flash_nOE=0.
  - At bit 24 rise, latch D into rdata, then flash_nOE=1.
  - On SCK falls after bits 24..31, cpld_MISO presents rdata[7]..rdata[0], so the master samples them during bits 25..32.
- Write (rnw=0):
  - At bit 28 rise, latch data and drive D=data. D stays driven until end of frame.
  - flash_nWE=0 from bit 29 rise to bit 31 rise, then 1.
  - Address and data are stable for the whole low pulse.
- cpld_MISO=0 outside the read data bits and while SS is high.
- Frame end (bit 32 rise): if all 32 received bits are 1 (0xFFFFFFFF), set allowing_bbc_access=1 at the next clk. Any other frame leaves it at 0.
- 0xFFFFFFFF also decodes as a read of 0x7FFFF; that read is harmless.
- Extra SCK pulses beyond 32 while SS is low are ignored until SS rises.
- rst_n assertion mid-frame aborts the frame immediately and returns to BBC mode.

Decomposition:
- Package master_updateable_megarom_pkg holds:
  - FRAME_BITS=32, ADDR_BITS=19, BBC_ADDR_BITS=17.
  - Bit-position constants: ADDR_END=19, RNW_BIT=20, READ_LATCH_BIT=24, DATA_END=28, WE_START=29, WE_END=31.
  - UNLOCK_WORD=32'hFFFFFFFF.
- One sub-module, spi_edge_sync: synchroniser plus SCK rise/fall and SS rise/fall pulse generation.

Test Plan:
- Reset, idle 10 clk, bbc_A=17'h12345, cpld_JP=0: allowing_bbc_access=1, flash_A=0x12345, flash_nOE=0, D high-Z.
- Frame 0xFFFFFF00 completes: allowing_bbc_access=0. Then frame 0xFFFFFFFF: allowing_bbc_access=1, flash_A tracks {JP,bbc_A} again.
- Write frame {19'h51234,0,8'h89,4'b0}: exactly one flash_nWE low pulse with flash_A=0x51234 and D=0x89; flash_nOE stays high; access remains disabled.
- Read frame {19'h70F0F,1,12'b0}, flash returns 0x42 while nOE low: one flash_nOE low pulse at 0x70F0F; last 8 MISO bits = 0x42; no nWE pulse.
- JEDEC sequence W5555/AA, W2AAA/55, W5555/90, R0, R1, W5555/F0: strobes appear in that order with those addresses and data.
- SS raised after 22 bits of a write frame: no nWE pulse, D released, allowing_bbc_access=0. Assert rst_n low mid-read: nOE/MISO return to reset values, BBC mode restored.
